// File: rtl/fpu_dispatch_pkg.sv
// Shared encodings, constants and types for the FPU command dispatcher.
package fpu_dispatch_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_HOLD  = 2'd3;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/fpu_dispatch_if.sv
// Command, fpu-core and result channels of the dispatcher; slave = dispatcher side.
interface fpu_dispatch_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_op;

  logic        fpu_start;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [1:0]  fpu_op;
  logic        fpu_done;
  logic [31:0] fpu_r;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r;
  logic [1:0]  out_op;
  logic        out_timeout;

  modport master (
    output in_valid, in_a, in_b, in_op, fpu_done, fpu_r, out_ready,
    input  in_ready, fpu_start, fpu_a, fpu_b, fpu_op, out_valid, out_r, out_op, out_timeout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, fpu_done, fpu_r, out_ready,
    output in_ready, fpu_start, fpu_a, fpu_b, fpu_op, out_valid, out_r, out_op, out_timeout
  );

endinterface

// File: rtl/fpu_cmd_fifo.sv
// Synchronous show-ahead command FIFO; head visible one cycle after push, no bypass.
// A full FIFO refuses a push even when a pop happens in the same cycle.
module fpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fpu_dispatch.sv
// Queues fpu commands, issues one at a time via start/done, returns results on valid/ready in order.
// Optional FPU_DISPATCH_TIMEOUT_EN forces a qNaN result after TIMEOUT WAIT cycles without fpu_done.
module fpu_dispatch
  import fpu_dispatch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst_n,
  fpu_dispatch_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_err
    $error("fpu_dispatch: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  cmd_t          fifo_wdat;
  cmd_t          fifo_head;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  state_t      state_q, state_d;
  logic [31:0] fpu_a_q, fpu_a_d;
  logic [31:0] fpu_b_q, fpu_b_d;
  logic [1:0]  fpu_op_q, fpu_op_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_r_q, out_r_d;
  logic [1:0]  out_op_q, out_op_d;
  logic        out_timeout_q, out_timeout_d;
  logic        expire;

  assign fifo_wdat = '{op: bus.in_op, a: bus.in_a, b: bus.in_b};
  assign fifo_push = bus.in_valid && !fifo_full;

  fpu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (fifo_push),
    .push_dat_i (fifo_wdat),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

`ifdef FPU_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt_q;

  // Counts completed WAIT cycles; cleared while in ISSUE so it starts at zero on WAIT entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_ISSUE) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      wait_cnt_q <= wait_cnt_q + TW'(1);
    end
  end

  assign expire = (state_q == ST_WAIT) && (wait_cnt_q == TW'(TIMEOUT - 1));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    fpu_a_d       = fpu_a_q;
    fpu_b_d       = fpu_b_q;
    fpu_op_d      = fpu_op_q;
    out_valid_d   = out_valid_q;
    out_r_d       = out_r_q;
    out_op_d      = out_op_q;
    out_timeout_d = out_timeout_q;
    fifo_pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          fpu_a_d  = fifo_head.a;
          fpu_b_d  = fifo_head.b;
          fpu_op_d = fifo_head.op;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // A real completion beats a timeout expiring in the same cycle.
        if (bus.fpu_done) begin
          out_valid_d   = 1'b1;
          out_r_d       = bus.fpu_r;
          out_op_d      = fpu_op_q;
          out_timeout_d = 1'b0;
          state_d       = ST_HOLD;
        end else if (expire) begin
          out_valid_d   = 1'b1;
          out_r_d       = QNAN;
          out_op_d      = fpu_op_q;
          out_timeout_d = 1'b1;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            fpu_a_d  = fifo_head.a;
            fpu_b_d  = fifo_head.b;
            fpu_op_d = fifo_head.op;
            state_d  = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      fpu_a_q       <= '0;
      fpu_b_q       <= '0;
      fpu_op_q      <= OP_ADD;
      out_valid_q   <= 1'b0;
      out_r_q       <= '0;
      out_op_q      <= OP_ADD;
      out_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fpu_a_q       <= fpu_a_d;
      fpu_b_q       <= fpu_b_d;
      fpu_op_q      <= fpu_op_d;
      out_valid_q   <= out_valid_d;
      out_r_q       <= out_r_d;
      out_op_q      <= out_op_d;
      out_timeout_q <= out_timeout_d;
    end
  end

  assign bus.in_ready    = (fifo_count != CW'(DEPTH));
  assign bus.fpu_start   = (state_q == ST_ISSUE);
  assign bus.fpu_a       = fpu_a_q;
  assign bus.fpu_b       = fpu_b_q;
  assign bus.fpu_op      = fpu_op_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_r       = out_r_q;
  assign bus.out_op      = out_op_q;
  assign bus.out_timeout = out_timeout_q;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed bench for fpu_dispatch with a 5-cycle stub fpu; inputs driven and outputs sampled on negedge.
module tb_fpu_dispatch;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fpu_dispatch_if bus ();

  fpu_dispatch #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [103:0] RST_SNAP = {1'b1, 103'd0};

  logic        stub_en   = 1'b1;
  logic        stub_done = 1'b0;
  logic [31:0] stub_r    = '0;
  int          stub_lat  = 0;
  int          n_start   = 0;

  assign bus.fpu_done = stub_done;
  assign bus.fpu_r    = stub_r;

  function automatic logic [31:0] stub_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] op);
    case ({op, a, b})
      {2'b00, 32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
      {2'b01, 32'h4040_0000, 32'h3F80_0000}: return 32'h4000_0000;
      {2'b10, 32'h4000_0000, 32'h4040_0000}: return 32'h40C0_0000;
      {2'b11, 32'h3F80_0000, 32'h4000_0000}: return 32'h3F00_0000;
      {2'b00, 32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;
      {2'b10, 32'h4040_0000, 32'h4040_0000}: return 32'h4110_0000;
      {2'b11, 32'h40C0_0000, 32'h4000_0000}: return 32'h4040_0000;
      default:                               return a ^ b;
    endcase
  endfunction

  // Stub core: done pulses five edges after the start pulse is sampled; keeps running through DUT reset.
  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (bus.fpu_start) n_start <= n_start + 1;
    if (stub_en && bus.fpu_start) begin
      stub_lat <= 5;
      stub_r   <= stub_model(bus.fpu_a, bus.fpu_b, bus.fpu_op);
    end else if (stub_lat != 0) begin
      stub_lat <= stub_lat - 1;
      if (stub_lat == 1) stub_done <= 1'b1;
    end
  end

  function automatic logic [103:0] snap();
    return {bus.in_ready, bus.fpu_start, bus.fpu_a, bus.fpu_b, bus.fpu_op,
            bus.out_valid, bus.out_r, bus.out_op, bus.out_timeout};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_start(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.fpu_start === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (snap() !== RST_SNAP) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want %h", snap(), RST_SNAP);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (snap() !== RST_SNAP) begin
      n_bad++;
      $display("FAIL reset_idle_after_release: got %h want %h", snap(), RST_SNAP);
    end
  endtask

  task automatic test_single_add();
    int c;
    int n0;
    n0 = n_start;
    @(negedge clk);
    drive(32'h3F80_0000, 32'h4000_0000, 2'b00);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.fpu_start !== 1'b0) begin
      n_bad++;
      $display("FAIL add_no_bypass: fpu_start got %b want 0", bus.fpu_start);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.fpu_start, bus.fpu_a, bus.fpu_b, bus.fpu_op} !== {1'b1, 32'h3F80_0000, 32'h4000_0000, 2'b00}) begin
      n_bad++;
      $display("FAIL add_issue: start/a/b/op got %b %h %h %b", bus.fpu_start, bus.fpu_a, bus.fpu_b, bus.fpu_op);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.fpu_start !== 1'b0 || bus.fpu_a !== 32'h3F80_0000) begin
      n_bad++;
      $display("FAIL add_start_one_cycle: start %b a %h want 0 3f800000", bus.fpu_start, bus.fpu_a);
    end
    wait_out(c);
    n_cmp++;
    if (c != 6) begin
      n_bad++;
      $display("FAIL add_latency: got %0d want 6 cycles", c);
    end
    n_cmp++;
    if ({bus.out_r, bus.out_op, bus.out_timeout} !== {32'h4040_0000, 2'b00, 1'b0}) begin
      n_bad++;
      $display("FAIL add_result: r %h op %b to %b want 40400000 00 0", bus.out_r, bus.out_op, bus.out_timeout);
    end
    n_cmp++;
    if (n_start - n0 != 1) begin
      n_bad++;
      $display("FAIL add_start_count: got %0d want 1", n_start - n0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL add_accept_clears: out_valid got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_fill();
    int c;
    int nv;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== (i < 5)) begin
        n_bad++;
        $display("FAIL fill_in_ready_%0d: got %b want %b", i, bus.in_ready, (i < 5));
      end
      drive(32'h1111_0000 + i, 32'h0F0F_0000, 2'(i));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_full_after_refuse: got %b want 0", bus.in_ready);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_out(c);
      n_cmp++;
      if (c == 0 || bus.out_r !== ((32'h1111_0000 + k) ^ 32'h0F0F_0000) || bus.out_op !== 2'(k)) begin
        n_bad++;
        $display("FAIL fill_drain_%0d: cyc %0d r %h op %b want r %h op %0d", k, c, bus.out_r, bus.out_op,
                 (32'h1111_0000 + k) ^ 32'h0F0F_0000, k % 4);
      end
    end
    nv = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 || bus.fpu_start === 1'b1) nv++;
    end
    bus.out_ready = 1'b0;
    n_cmp++;
    if (nv != 0) begin
      n_bad++;
      $display("FAIL fill_sixth_dropped: activity cycles got %0d want 0", nv);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea [4];
    logic [31:0] eb [4];
    logic [1:0]  eo [4];
    logic [31:0] er [4];
    int c;
    ea = '{32'h4040_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000};
    eb = '{32'h3F80_0000, 32'h4040_0000, 32'h4000_0000, 32'h4000_0000};
    eo = '{2'b01, 2'b10, 2'b11, 2'b00};
    er = '{32'h4000_0000, 32'h40C0_0000, 32'h3F00_0000, 32'h4080_0000};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(ea[i], eb[i], eo[i]);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_out(c);
      n_cmp++;
      if (c == 0 || bus.out_r !== er[k] || bus.out_op !== eo[k]) begin
        n_bad++;
        $display("FAIL b2b_result_%0d: cyc %0d r %h op %b want %h %b", k, c, bus.out_r, bus.out_op, er[k], eo[k]);
      end
      if (k < 3) begin
        @(negedge clk);
        n_cmp++;
        if (bus.fpu_start !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_start_%0d: fpu_start got %b want 1", k, bus.fpu_start);
        end
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int c;
    int bad;
    int n0;
    n0 = n_start;
    bus.out_ready = 1'b0;
    @(negedge clk);
    drive(32'h4000_0000, 32'h4000_0000, 2'b00);
    @(negedge clk);
    drive(32'h4040_0000, 32'h4040_0000, 2'b10);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(c);
    n_cmp++;
    if (c == 0 || bus.out_r !== 32'h4080_0000) begin
      n_bad++;
      $display("FAIL bp_first: cyc %0d r %h want 40800000", c, bus.out_r);
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_r !== 32'h4080_0000 || bus.fpu_start !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL bp_hold_stable: unstable cycles got %0d want 0", bad);
    end
    n_cmp++;
    if (n_start - n0 != 1) begin
      n_bad++;
      $display("FAIL bp_no_new_start: starts got %0d want 1", n_start - n0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.fpu_start !== 1'b1 || bus.out_valid !== 1'b0 || bus.fpu_op !== 2'b10) begin
      n_bad++;
      $display("FAIL bp_release: start %b valid %b op %b want 1 0 10", bus.fpu_start, bus.out_valid, bus.fpu_op);
    end
    wait_out(c);
    n_cmp++;
    if (c == 0 || bus.out_r !== 32'h4110_0000 || bus.out_op !== 2'b10) begin
      n_bad++;
      $display("FAIL bp_second: cyc %0d r %h op %b want 41100000 10", c, bus.out_r, bus.out_op);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n0;
    int nv;
    n0 = n_start;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(32'h3F80_0000, 32'h4000_0000, 2'b00);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (n_start - n0 != 1 || bus.fpu_a !== 32'h3F80_0000) begin
      n_bad++;
      $display("FAIL rst_mid_in_wait: starts %0d a %h want 1 3f800000", n_start - n0, bus.fpu_a);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (snap() !== RST_SNAP) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got %h want %h", snap(), RST_SNAP);
    end
    rst_n = 1'b1;
    nv = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 || bus.fpu_start === 1'b1) nv++;
    end
    n_cmp++;
    if (nv != 0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_discard: activity %0d in_ready %b want 0 1", nv, bus.in_ready);
    end
  endtask

  task automatic test_timeout();
    int c;
    stub_en       = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    drive(32'h1234_5678, 32'h9ABC_DEF0, 2'b10);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_start(c);
    n_cmp++;
    if (c == 0) begin
      n_bad++;
      $display("FAIL tmo_issue: fpu_start never seen, got 0 want 1");
    end
    wait_out(c);
`ifdef FPU_DISPATCH_TIMEOUT_EN
    n_cmp++;
    if (c != 9 || bus.out_r !== 32'h7FC0_0000 || bus.out_timeout !== 1'b1 || bus.out_op !== 2'b10) begin
      n_bad++;
      $display("FAIL tmo_forced: cyc %0d r %h to %b op %b want 9 7fc00000 1 10", c, bus.out_r, bus.out_timeout,
               bus.out_op);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
`else
    n_cmp++;
    if (c != 0 || bus.out_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_disabled_waits: cyc %0d to %b want 0 0", c, bus.out_timeout);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    stub_en = 1'b1;
    @(negedge clk);
    drive(32'h40C0_0000, 32'h4000_0000, 2'b11);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(c);
    n_cmp++;
    if (c == 0 || bus.out_r !== 32'h4040_0000 || bus.out_timeout !== 1'b0 || bus.out_op !== 2'b11) begin
      n_bad++;
      $display("FAIL tmo_normal_after: cyc %0d r %h to %b op %b want 40400000 0 11", c, bus.out_r,
               bus.out_timeout, bus.out_op);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_fill();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
